alu_pipe: RTL and testbench

- Parametrised, two-stage pipelined successor to the single-function 32-bit OR unit.
- Eight logic and arithmetic operations are selected by an `op` field.
- Upstream and downstream each use a valid/ready handshake, with full backpressure.
- Sits between the register-read stage and the writeback mux. The result is registered, and a zero flag is produced.

---
 rtl/alu_pipe.sv | 121 ++++++++++++
 tb/tb_alu_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined 8-op ALU with zero flag; `ifdef ALU_FLAGS_EN adds carry/overflow outputs.
// Latency 2 cycles from accept to out_valid; 1 op/cycle when out_ready is held high.
// Full valid/ready backpressure: in_ready = !v1 | !v2 | out_ready, outputs hold while stalled.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow
`endif
);

  logic             v1_q, v2_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic [WIDTH-1:0] y_d;
  logic [OPW+3:0]   op_ext;
  logic             adv1, adv2;

  assign adv2      = !v2_q || out_ready;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign y         = y_q;
  assign zero      = zero_q;

  // Op values at or above 8 (only reachable when OPW > 3) produce zero.
  always_comb begin
    op_ext = '0;
    op_ext[OPW-1:0] = op_q;
    y_d = '0;
    if (op_ext[OPW+3:3] == '0) begin
      case (op_ext[2:0])
        3'd0:    y_d = a_q & b_q;
        3'd1:    y_d = a_q | b_q;
        3'd2:    y_d = a_q ^ b_q;
        3'd3:    y_d = ~(a_q | b_q);
        3'd4:    y_d = a_q + b_q;
        3'd5:    y_d = a_q - b_q;
        3'd6:    y_d[0] = $signed(a_q) < $signed(b_q);
        default: y_d[0] = a_q < b_q;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic carry_q, overflow_q;
  logic carry_d, overflow_d;

  // Carry and overflow are recovered from the wrapped result rather than a wider adder.
  always_comb begin
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    if (op_ext == (OPW+4)'(4)) begin
      carry_d    = y_d < a_q;
      overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
    end else if (op_ext == (OPW+4)'(5)) begin
      carry_d    = a_q >= b_q;
      overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  assign carry    = carry_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (adv2 && v1_q) begin
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      y_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          a_q  <= a;
          b_q  <= b;
          op_q <= op;
        end
      end
      // y keeps its last value when nothing moves into stage 2.
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          y_q    <= y_d;
          zero_q <= (y_d == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 32-bit instance checked against a queue model, 8-bit instance by literals.
module tb_alu_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [2:0]  op;
  logic [31:0] a, b, y;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, y8;
`ifdef ALU_FLAGS_EN
  logic carry, overflow, carry8, overflow8;
`endif

  alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero)
`ifdef ALU_FLAGS_EN
    , .carry(carry), .overflow(overflow)
`endif
  );

  alu_pipe #(.WIDTH(8), .OPW(4)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .y(y8), .zero(zero8)
`ifdef ALU_FLAGS_EN
    , .carry(carry8), .overflow(overflow8)
`endif
  );

  typedef struct {
    logic [31:0] y;
    logic        z;
    logic        c;
    logic        v;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } log_t;

  res_t expq[$];
  log_t lg[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  // Reference arithmetic on 64-bit integers, independent of bit-level tricks.
  function automatic res_t model(int w, logic [3:0] o, logic [31:0] ai, logic [31:0] bi);
    res_t   r;
    longint m, ua, ub, sa, sb, rr, s;
    m  = longint'(1) << w;
    ua = longint'(ai) & (m - 1);
    ub = longint'(bi) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r.c = 1'b0;
    r.v = 1'b0;
    rr  = 0;
    case (o)
      4'd0: rr = ua & ub;
      4'd1: rr = ua | ub;
      4'd2: rr = ua ^ ub;
      4'd3: rr = ~(ua | ub) & (m - 1);
      4'd4: begin
        rr  = ua + ub;
        r.c = rr >= m;
        rr  = rr % m;
        s   = sa + sb;
        r.v = (s >= m / 2) || (s < -(m / 2));
      end
      4'd5: begin
        r.c = ua >= ub;
        rr  = (ua - ub + m) % m;
        s   = sa - sb;
        r.v = (s >= m / 2) || (s < -(m / 2));
      end
      4'd6: rr = (sa < sb) ? 1 : 0;
      4'd7: rr = (ua < ub) ? 1 : 0;
      default: rr = 0;
    endcase
    r.y = rr[31:0];
    r.z = (rr == 0);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every output transfer is matched against the model queue in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
    end else begin
      if (out_valid && out_ready) begin
        log_t l;
        res_t e;
        l.r.y = y;
        l.r.z = zero;
        l.r.c = 1'b0;
        l.r.v = 1'b0;
`ifdef ALU_FLAGS_EN
        l.r.c = carry;
        l.r.v = overflow;
`endif
        l.cyc = cyc;
        lg.push_back(l);
        n_vec++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: y=%h with nothing outstanding", y);
        end else begin
          e = expq.pop_front();
          if (l.r.y !== e.y || l.r.z !== e.z || l.r.c !== e.c || l.r.v !== e.v) begin
            n_err++;
            $display("FAIL stream: got y=%h z=%b c=%b v=%b, expected y=%h z=%b c=%b v=%b",
                     l.r.y, l.r.z, l.r.c, l.r.v, e.y, e.z, e.c, e.v);
          end
        end
      end
      if (in_valid && in_ready) begin
        res_t m;
        m = model(32, {1'b0, op}, a, b);
`ifndef ALU_FLAGS_EN
        m.c = 1'b0;
        m.v = 1'b0;
`endif
        expq.push_back(m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [2:0] o, logic [31:0] oa, logic [31:0] ob);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    op = o;
    a = oa;
    b = ob;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] xa, xb;
    rst_n = 1'b1;
    in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst8_out_valid", out_valid8, 0);
    chk("rst8_y", y8, 0);
`ifdef ALU_FLAGS_EN
    chk("rst_carry", carry, 0);
    chk("rst_overflow", overflow, 0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    // Single OR, two-cycle latency
    send(3'd1, 32'hF0F0_0000, 32'h0000_0F0F);
    @(negedge clk);
    chk("or_valid_early", out_valid, 0);
    step();
    @(negedge clk);
    chk("or_valid", out_valid, 1);
    chk("or_y", y, 32'hF0F0_0F0F);
    chk("or_zero", zero, 0);
    step();

    // Back-to-back arithmetic and compares
    base = lg.size();
    send(3'd4, 32'hFFFF_FFFF, 32'h1);
    send(3'd5, 32'd5, 32'd5);
    send(3'd6, 32'h8000_0000, 32'h1);
    send(3'd7, 32'h8000_0000, 32'h1);
    repeat (4) step();
    chk("b2b_count", lg.size() - base, 4);
    if (lg.size() >= base + 4) begin
      chk("add_y", lg[base].r.y, 0);
      chk("add_zero", lg[base].r.z, 1);
      chk("sub_y", lg[base+1].r.y, 0);
      chk("sub_zero", lg[base+1].r.z, 1);
      chk("slt_y", lg[base+2].r.y, 1);
      chk("sltu_y", lg[base+3].r.y, 0);
      chk("b2b_span", lg[base+3].cyc - lg[base].cyc, 3);
`ifdef ALU_FLAGS_EN
      chk("add_carry", lg[base].r.c, 1);
      chk("add_overflow", lg[base].r.v, 0);
      chk("sub_carry", lg[base+1].r.c, 1);
`endif
    end

    // Backpressure: two fill the pipe, third waits
    out_ready = 1'b0;
    base = lg.size();
    in_valid = 1'b1; op = 3'd2; a = 32'h1; b = 32'h2;
    @(negedge clk);
    chk("bp_rdy1", in_ready, 1);
    step();
    op = 3'd0; a = 32'hFF00; b = 32'h0F0F;
    @(negedge clk);
    chk("bp_rdy2", in_ready, 1);
    step();
    op = 3'd4; a = 32'h10; b = 32'h20;
    @(negedge clk);
    chk("bp_rdy3_blocked", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_y", y, 32'h3);
    step();
    @(negedge clk);
    chk("bp_rdy3_still_blocked", in_ready, 0);
    chk("bp_y_stable", y, 32'h3);
    chk("bp_valid_stable", out_valid, 1);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rdy_release", in_ready, 1);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("bp_count", lg.size() - base, 3);
    if (lg.size() >= base + 3) begin
      chk("bp_r0", lg[base].r.y, 32'h3);
      chk("bp_r1", lg[base+1].r.y, 32'h0F00);
      chk("bp_r2", lg[base+2].r.y, 32'h30);
      chk("bp_span", lg[base+2].cyc - lg[base].cyc, 2);
    end

    // Streaming XOR, one per cycle
    base = lg.size();
    for (int i = 0; i < 10; i++) begin
      xa = 32'hA5A5_0000 + 32'(i) * 32'h0101_0101;
      xb = 32'h0F0F_1234 ^ (32'(i) << 8);
      send(3'd2, xa, xb);
    end
    repeat (3) step();
    chk("xor_count", lg.size() - base, 10);
    if (lg.size() >= base + 10) begin
      chk("xor_first", lg[base].r.y, 32'hA5A5_0000 ^ 32'h0F0F_1234);
      chk("xor_span", lg[base+9].cyc - lg[base].cyc, 9);
    end

    // Reset with both stages occupied
    out_ready = 1'b0;
    send(3'd4, 32'd1, 32'd2);
    send(3'd5, 32'd9, 32'd3);
    chk("inflight_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_y", y, 0);
    chk("arst_zero", zero, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    base = lg.size();
    repeat (5) step();
    chk("no_stale_count", lg.size() - base, 0);
    chk("no_stale_valid", out_valid, 0);

    // 8-bit, 4-bit-op instance
    in_valid8 = 1'b1; op8 = 4'd4; a8 = 8'h7F; b8 = 8'h01;
    step();
    in_valid8 = 1'b0;
    step();
    @(negedge clk);
    chk("w8_add_valid", out_valid8, 1);
    chk("w8_add_y", y8, 8'h80);
    chk("w8_add_zero", zero8, 0);
`ifdef ALU_FLAGS_EN
    chk("w8_add_overflow", overflow8, 1);
    chk("w8_add_carry", carry8, 0);
`endif
    step();
    in_valid8 = 1'b1; op8 = 4'd3; a8 = 8'h00; b8 = 8'h00;
    step();
    in_valid8 = 1'b0;
    step();
    @(negedge clk);
    chk("w8_nor_y", y8, 8'hFF);
    step();
    in_valid8 = 1'b1; op8 = 4'd8; a8 = 8'h05; b8 = 8'h03;
    step();
    in_valid8 = 1'b0;
    step();
    @(negedge clk);
    chk("w8_op8_y", y8, 8'h00);
    chk("w8_op8_zero", zero8, 1);
    step();

    chk("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
